// File: rtl/apb_cmd_initiator.sv
// rtl/apb_cmd_initiator.sv - APB initiator fed by a command FIFO, with read-response port and per-transfer timeout
//
// Purpose:
//   Accepts read/write commands on a valid/ready port, queues them in a DEPTH-entry
//   FIFO and issues each as an APB transfer (SETUP then ACCESS, honouring PREADY
//   wait states). Read data returns on a valid/ready response port. A transfer whose
//   responder holds PREADY low for TIMEOUT ACCESS cycles is aborted.
//
// Optional feature macro: APB_SLVERR_EN
//   When defined, adds input PSLVERR and sticky output wr_err.
//
// Ports:
//   PCLK, PRESETn                  clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_addr/cmd_wdata   command payload (1 = write)
//   rsp_valid/rsp_ready            read response handshake
//   rsp_rdata/rsp_err              read data and error flag (timeout or PSLVERR)
//   busy                           FIFO non-empty or transfer in progress
//   txn_cnt                        completed transfer count, wraps
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request outputs (all registered)
//   PRDATA/PREADY                  APB responder inputs
//   PSLVERR, wr_err                only with APB_SLVERR_EN

module apb_cmd_initiator #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [15:0]       txn_cnt,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
`ifdef APB_SLVERR_EN
    ,
    input  logic              PSLVERR,
    output logic              wr_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t state, state_nxt;

    // Command FIFO
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];
    logic [DEPTH-1:0]  fifo_write;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head_write = fifo_write[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_wdata = fifo_wdata[rd_ptr];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
            fifo_write[wr_ptr] <= cmd_write;
        end
    end

    // A read may only launch when the response slot is free, and anything
    // behind a stalled read waits too, which keeps ordering intact.
    logic launch_ok;
    assign launch_ok = !fifo_empty && (head_write || !rsp_valid);

    // When chaining out of a completing read, the response slot is about to be
    // filled, so only a write may follow immediately.
    logic chain_ok;
    assign chain_ok = !fifo_empty && (head_write || (!rsp_valid && PWRITE));

    // Timeout
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            to_hit;

    generate
        if (TIMEOUT == 0) begin : g_no_to
            assign to_hit = 1'b0;
        end else begin : g_to
            assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
        end
    endgenerate

    logic              psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              txn_inc;
`ifdef APB_SLVERR_EN
    logic              wr_err_set;
`endif

    always_comb begin
        state_nxt     = state;
        psel_nxt      = PSEL;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        paddr_nxt     = PADDR;
        pwdata_nxt    = PWDATA;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        to_cnt_nxt    = to_cnt;
        txn_inc       = 1'b0;
        pop           = 1'b0;
`ifdef APB_SLVERR_EN
        wr_err_set    = 1'b0;
`endif

        if (rsp_valid && rsp_ready) rsp_valid_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (launch_ok) begin
                    pop         = 1'b1;
                    paddr_nxt   = head_addr;
                    pwdata_nxt  = head_wdata;
                    pwrite_nxt  = head_write;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    state_nxt   = S_SETUP;
                end
            end

            S_SETUP: begin
                penable_nxt = 1'b1;
                to_cnt_nxt  = '0;
                state_nxt   = S_ACCESS;
            end

            S_ACCESS: begin
                if (PREADY) begin
                    txn_inc = 1'b1;
                    if (!PWRITE) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = PRDATA;
`ifdef APB_SLVERR_EN
                        rsp_err_nxt   = PSLVERR;
`else
                        rsp_err_nxt   = 1'b0;
`endif
                    end
`ifdef APB_SLVERR_EN
                    else if (PSLVERR) begin
                        wr_err_set = 1'b1;
                    end
`endif
                    if (chain_ok) begin
                        pop         = 1'b1;
                        paddr_nxt   = head_addr;
                        pwdata_nxt  = head_wdata;
                        pwrite_nxt  = head_write;
                        penable_nxt = 1'b0;
                        state_nxt   = S_SETUP;
                    end else begin
                        psel_nxt    = 1'b0;
                        penable_nxt = 1'b0;
                        state_nxt   = S_IDLE;
                    end
                end else if (to_hit) begin
                    txn_inc     = 1'b1;
                    psel_nxt    = 1'b0;
                    penable_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                    if (!PWRITE) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = '0;
                        rsp_err_nxt   = 1'b1;
                    end
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end

            default: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            to_cnt    <= '0;
            txn_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            to_cnt    <= to_cnt_nxt;
            if (txn_inc) txn_cnt <= txn_cnt + 16'd1;
        end
    end

`ifdef APB_SLVERR_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)        wr_err <= 1'b0;
        else if (wr_err_set) wr_err <= 1'b1;
    end
`endif

    assign busy = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// tb/tb_apb_cmd_initiator.sv - self-checking bench for apb_cmd_initiator with a subtractor responder model
module tb_apb_cmd_initiator;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [15:0] txn_cnt;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY = 1'b1;
`ifdef APB_SLVERR_EN
    logic        PSLVERR = 1'b0;
    logic        wr_err;
`endif

    apb_cmd_initiator #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .txn_cnt(txn_cnt),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
`ifdef APB_SLVERR_EN
        , .PSLVERR(PSLVERR), .wr_err(wr_err)
`endif
    );

    always #5 PCLK = ~PCLK;

    // Subtractor responder: 0x0 loads A and the accumulator, 0x4 loads B,
    // writing 1 to 0x8 subtracts B from the accumulator, 0xC reads the accumulator.
    logic [31:0] per_a = '0, per_b = '0, per_acc = '0;
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE) begin
            case (PADDR)
                32'h0: begin per_a <= PWDATA; per_acc <= PWDATA; end
                32'h4: per_b <= PWDATA;
                32'h8: if (PWDATA[0]) per_acc <= per_acc - per_b;
                default: ;
            endcase
        end
    end
    always_comb begin
        case (PADDR)
            32'h0:   PRDATA = per_a;
            32'h4:   PRDATA = per_b;
            32'hC:   PRDATA = per_acc;
            default: PRDATA = 32'h0;
        endcase
    end

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } apb_t;
    typedef struct { logic [31:0] d; logic e; } rsp_t;
    typedef struct { logic w; logic [31:0] a; logic [31:0] d; logic [31:0] exp_rd; } vec_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int psel_cnt = 0, psel_first = -1, psel_last = -1, acc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards when the DUT completes an APB transfer or a response handshake.
    always @(negedge PCLK) begin
        apb_t ea;
        rsp_t er;
        cyc++;
        if (PRESETn) begin
            if (PSEL) begin
                psel_cnt++;
                if (psel_first < 0) psel_first = cyc;
                psel_last = cyc;
            end
            if (PSEL && PENABLE) acc_cnt++;
            if (PSEL && PENABLE && PREADY) begin
                if (apb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL apb_unexpected actual=transfer addr 0x%0h required=none", PADDR);
                end else begin
                    ea = apb_q.pop_front();
                    check("apb_addr", PADDR, ea.a);
                    check("apb_write", {31'd0, PWRITE}, {31'd0, ea.w});
                    if (ea.w) check("apb_wdata", PWDATA, ea.d);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected actual=rdata 0x%0h required=none", rsp_rdata);
                end else begin
                    er = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, er.d);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, er.e});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e);
        int n = 0;
        apb_t ea;
        rsp_t er;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        forever begin
            @(negedge PCLK);
            if (cmd_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            check("push_timeout", {31'd0, cmd_ready}, 32'd1);
            @(posedge PCLK); #1;
            cmd_valid = 1'b0;
        end else begin
            ea.w = w; ea.a = a; ea.d = d;
            apb_q.push_back(ea);
            if (!w) begin
                er.d = exp_d; er.e = exp_e;
                rsp_q.push_back(er);
            end
            @(posedge PCLK); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (busy && n < budget);
        check(name, {31'd0, busy}, 32'd0);
        @(posedge PCLK); #1;
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        int seen;

        vecs[0] = '{w: 1'b1, a: 32'h0, d: 32'd15, exp_rd: 32'd0};
        vecs[1] = '{w: 1'b1, a: 32'h4, d: 32'd3,  exp_rd: 32'd0};
        vecs[2] = '{w: 1'b1, a: 32'h8, d: 32'd1,  exp_rd: 32'd0};
        vecs[3] = '{w: 1'b1, a: 32'h8, d: 32'd1,  exp_rd: 32'd0};
        vecs[4] = '{w: 1'b0, a: 32'hC, d: 32'd0,  exp_rd: 32'd9};

        // Reset state
        #1 PRESETn = 1'b0;
        #1;
        check("rst_psel",    {31'd0, PSEL},      32'd0);
        check("rst_penable", {31'd0, PENABLE},   32'd0);
        check("rst_pwrite",  {31'd0, PWRITE},    32'd0);
        check("rst_paddr",   PADDR,              32'd0);
        check("rst_pwdata",  PWDATA,             32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata,        32'd0);
        check("rst_rsp_err", {31'd0, rsp_err},   32'd0);
        check("rst_txn_cnt", {16'd0, txn_cnt},   32'd0);
        check("rst_busy",    {31'd0, busy},      32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge PCLK); #1;

        // Subtractor sequence, back-to-back
        psel_cnt = 0; psel_first = -1; psel_last = -1;
        for (int i = 0; i < 5; i++) push(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 1'b0);
        wait_idle("t1_idle", 40);
        check("t1_txn_cnt", {16'd0, txn_cnt}, 32'd5);
        check("t1_psel_cycles", psel_cnt, 32'd10);
        check("t1_psel_span", psel_last - psel_first + 1, 32'd10);

        // Latency of a single read; response left pending
        rsp_ready = 1'b0;
        push(1'b0, 32'h4, 32'd0, 32'd3, 1'b0);
        @(negedge PCLK);
        check("lat_k_psel", {31'd0, PSEL}, 32'd0);
        @(negedge PCLK);
        check("lat_k1_psel", {31'd0, PSEL}, 32'd1);
        check("lat_k1_penable", {31'd0, PENABLE}, 32'd0);
        @(negedge PCLK);
        check("lat_k2_penable", {31'd0, PENABLE}, 32'd1);
        @(negedge PCLK);
        check("lat_k3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("lat_k3_rdata", rsp_rdata, 32'd3);
        check("lat_k3_psel", {31'd0, PSEL}, 32'd0);
        @(posedge PCLK); #1;

        // Read stalled behind a held response, write queued behind it
        push(1'b0, 32'h0, 32'd0, 32'd15, 1'b0);
        push(1'b1, 32'h4, 32'd7, 32'd0, 1'b0);
        psel_cnt = 0;
        repeat (5) @(negedge PCLK);
        check("t2_stalled_psel", psel_cnt, 32'd0);
        check("t2_held_rdata", rsp_rdata, 32'd3);
        @(posedge PCLK); #1 rsp_ready = 1'b1;
        @(posedge PCLK); #1 rsp_ready = 1'b0;
        wait_idle("t2_idle", 20);
        check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("t2_rdata", rsp_rdata, 32'd15);
        repeat (3) @(negedge PCLK);
        check("t2_rdata_stable", rsp_rdata, 32'd15);
        check("t2_per_b", per_b, 32'd7);
        @(posedge PCLK); #1;

        // FIFO full while a read is stalled and PREADY low
        PREADY = 1'b0;
        push(1'b0, 32'hC, 32'd0, 32'd9, 1'b0);
        push(1'b1, 32'h8, 32'd1, 32'd0, 1'b0);
        push(1'b1, 32'h4, 32'd2, 32'd0, 1'b0);
        push(1'b1, 32'h8, 32'd1, 32'd0, 1'b0);
        @(negedge PCLK);
        check("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'd0;
        seen = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (cmd_ready) seen++;
        end
        check("t3_full_hold", seen, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge PCLK); #1 rsp_ready = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        PREADY = 1'b1;
        rsp_ready = 1'b1;
        wait_idle("t3_idle", 40);
        check("t3_txn_cnt", {16'd0, txn_cnt}, 32'd12);
        check("t3_per_acc", per_acc, 32'd0);

        // Read timeout
        rsp_ready = 1'b0;
        PREADY = 1'b0;
        acc_cnt = 0;
        push(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!rsp_valid && n < 40);
        check("to_access_cycles", acc_cnt, 32'd16);
        check("to_psel", {31'd0, PSEL}, 32'd0);
        check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        check("to_err", {31'd0, rsp_err}, 32'd1);
        check("to_txn_cnt", {16'd0, txn_cnt}, 32'd13);
        if (apb_q.size() != 0) void'(apb_q.pop_front());
        @(posedge PCLK); #1 rsp_ready = 1'b1;

        // Write timeout is silent apart from txn_cnt
        push(1'b1, 32'h4, 32'd5, 32'd0, 1'b0);
        wait_idle("wto_idle", 40);
        check("wto_txn_cnt", {16'd0, txn_cnt}, 32'd14);
        check("wto_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        if (apb_q.size() != 0) void'(apb_q.pop_front());

        // Reset during ACCESS
        push(1'b0, 32'h0, 32'd0, 32'd15, 1'b0);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PENABLE && n < 10);
        check("rst_mid_access", {31'd0, PENABLE}, 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_mid_psel", {31'd0, PSEL}, 32'd0);
        check("rst_mid_penable", {31'd0, PENABLE}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        apb_q.delete();
        rsp_q.delete();
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        PREADY = 1'b1;
        repeat (4) @(negedge PCLK);
        check("rst_post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_post_txn_cnt", {16'd0, txn_cnt}, 32'd0);
        check("rst_post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge PCLK); #1;

`ifdef APB_SLVERR_EN
        PSLVERR = 1'b1;
        push(1'b0, 32'h4, 32'd0, 32'd2, 1'b1);
        wait_idle("se_rd_idle", 20);
        push(1'b1, 32'h4, 32'd3, 32'd0, 1'b0);
        wait_idle("se_wr_idle", 20);
        check("se_wr_err", {31'd0, wr_err}, 32'd1);
        PSLVERR = 1'b0;
        push(1'b1, 32'h4, 32'd4, 32'd0, 1'b0);
        wait_idle("se_wr2_idle", 20);
        check("se_wr_err_sticky", {31'd0, wr_err}, 32'd1);
`endif

        repeat (2) @(negedge PCLK);
        check("end_apb_q_empty", apb_q.size(), 32'd0);
        check("end_rsp_q_empty", rsp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_cmd_initiator.md
Name: apb_cmd_initiator

Overview:
Hardware APB initiator that replaces testbench-driven stimulus. It accepts queued read/write commands on a valid/ready command port, then issues each one as a compliant APB transfer (SETUP then ACCESS, with PREADY wait states) to a single responder such as the subtractor peripheral. Read data returns on a valid/ready response port. A per-transfer timeout prevents a hung responder from locking the bus.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
TIMEOUT, 16, maximum ACCESS cycles to wait for PREADY; 0 disables the timeout.
ADDR_W, 32, PADDR and cmd_addr width.
DATA_W, 32, PWDATA, PRDATA, cmd_wdata and rsp_rdata width.

Ports:
PCLK  in  1  bus clock; all logic on rising edge.
PRESETn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command FIFO not full.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  target register address.
cmd_wdata  in  DATA_W  write data; ignored for reads.
rsp_valid  out  1  read response held.
rsp_ready  in  1  response consumed.
rsp_rdata  out  DATA_W  captured read data.
rsp_err  out  1  response carries an error (timeout, or PSLVERR when enabled).
busy  out  1  FIFO non-empty or FSM not in IDLE.
txn_cnt  out  16  completed transfer count; wraps.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  ADDR_W  APB address.
PWDATA  out  DATA_W  APB write data.
PRDATA  in  DATA_W  APB read data.
PREADY  in  1  APB ready.

Behaviour:
- Reset (asynchronous, PRESETn=0): outputs clear immediately.
  - PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_cnt=0, busy=0.
  - FIFO is flushed; cmd_ready=1 after release.
  - Reset mid-transfer abandons the transfer without producing a response.
- Command FIFO:
  - Push when cmd_valid and cmd_ready.
  - cmd_ready = !full. When full, cmd_ready stays low even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are both honoured when the FIFO is neither full nor empty.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- Launch condition: FIFO non-empty AND (head is a write OR rsp_valid=0).
- IDLE:
  - If the launch condition holds, pop the head into PADDR, PWDATA and PWRITE, set PSEL=1 and PENABLE=0, and go to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - Sets PENABLE=1 and goes to ACCESS.
  - PADDR, PWRITE and PWDATA stay stable through SETUP and ACCESS.
- ACCESS, on PREADY=1:
  - The transfer completes and txn_cnt increments.
  - For a read, capture PRDATA into rsp_rdata, set rsp_valid=1 and rsp_err=0.
  - If the launch condition holds, go directly to SETUP with the next command (PSEL stays 1, PENABLE=0).
  - Otherwise PSEL=PENABLE=0 and go to IDLE.
- ACCESS, timeout:
  - Applies when TIMEOUT≠0 and PREADY has stayed low for TIMEOUT consecutive ACCESS cycles.
  - Abort: PSEL=PENABLE=0 and go to IDLE; txn_cnt still increments.
  - A read also produces rsp_valid=1, rsp_rdata=0, rsp_err=1.
  - A write timeout is silent apart from txn_cnt.
- Latency, empty FIFO, PREADY tied 1:
  - Command handshake at edge k.
  - PSEL=1 after edge k+1; PENABLE=1 after edge k+2.
  - Completion sampled at edge k+3; a read asserts rsp_valid after edge k+3.
- Back-to-back transfers: a new transfer takes 2 cycles with zero idle cycles.
- Response port:
  - rsp_valid stays high and rsp_rdata/rsp_err stay stable until rsp_ready.
  - It clears on the edge where rsp_valid and rsp_ready are both 1.
  - A pending read at the FIFO head stalls while rsp_valid=1; writes behind it also wait, so ordering is preserved.
- busy = FIFO non-empty OR state≠IDLE.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined:
  - Adds input PSLVERR (1 bit), sampled with PREADY=1 in ACCESS.
  - A read completing with PSLVERR=1 gives rsp_err=1, with rsp_rdata still captured from PRDATA.
  - A write completing with PSLVERR=1 sets sticky output wr_err, cleared only by reset.
- Undefined: no PSLVERR or wr_err ports exist; rsp_err reflects timeout only.

Test Plan:
- Subtractor sequence, PREADY=1: write 15→0x0, 3→0x4, 1→0x8, 1→0x8, then read 0xC → rsp_rdata=9, rsp_err=0, txn_cnt=5. Each APB transfer is exactly 2 cycles with no IDLE gaps.
- Read 0x0 with rsp_ready held 0, followed by write 7→0x4: the write is not issued until rsp_ready pulses. The first response stays stable at 15 throughout.
- Push DEPTH+1 commands with PREADY=0 held: cmd_ready drops after DEPTH accepted entries. Release PREADY: all DEPTH entries complete in order.
- PREADY held 0 for a read with TIMEOUT=16: PSEL drops after 16 ACCESS cycles; rsp_valid=1, rsp_rdata=0, rsp_err=1.
- Assert PRESETn=0 during ACCESS: PSEL, PENABLE and busy go 0 immediately. After release, no response is produced, txn_cnt=0 and cmd_ready=1.
- With APB_SLVERR_EN defined: PSLVERR=1 on a read of 0x4 gives rsp_err=1 and rsp_rdata=PRDATA. On a write it sets wr_err=1, which stays set.
